// File: rtl/router_pkt_tx.sv
// router_pkt_tx: host-loaded payload FIFO plus a framing FSM that sends
// header / payload / parity to the router input port, honours router
// back-pressure, and captures the router error status after each packet.
module router_pkt_tx #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned ERR_LAT    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          host_wr_en,
  input  logic [7:0]                    host_wr_data,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          wr_drop,
  input  logic                          send_req,
  input  logic [5:0]                    send_len,
  output logic                          send_ack,
  output logic                          send_rej,
  output logic [7:0]                    dut_inp,
  output logic                          inp_valid,
  input  logic                          busy,
  input  logic [3:0]                    error,
  output logic                          tx_active,
  output logic                          done,
  output logic [3:0]                    err_status
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [3:0]  ERR_LAT_C = 4'(ERR_LAT);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    PARITY,
    ERR_WAIT
  } state_e;

  state_e         state_q;
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           wr_drop_q;
  logic [7:0]     dut_inp_q;
  logic           inp_valid_q;
  logic [7:0]     parity_q;
  logic [5:0]     rem_q;
  logic [3:0]     lat_q;
  logic           send_ack_q;
  logic           send_rej_q;
  logic           tx_active_q;
  logic           done_q;
  logic [3:0]     err_status_q;

  logic           full;
  logic           xfer;
  logic           pop;
  logic           push;
  logic [7:0]     head;

  // Transfer qualification and FIFO push/pop decisions.
  // A byte is popped when it is loaded into dut_inp (on the header transfer
  // and on every payload transfer except the last), so the FIFO head is
  // always the next byte to present.
  always_comb begin
    full = (count_q == CW'(FIFO_DEPTH));
    xfer = inp_valid_q && !busy;
    pop  = xfer && ((state_q == HDR) || ((state_q == PAYLOAD) && (rem_q != 6'd1)));
    push = host_wr_en && (!full || pop);
    head = mem_q[rd_ptr_q];
  end

  // Payload storage; contents need no reset since count_q gates all reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= host_wr_data;
    end
  end

  // FIFO pointers, occupancy and drop indication.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      wr_drop_q <= host_wr_en && !push;
    end
  end

  // Packet framing FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      dut_inp_q    <= '0;
      inp_valid_q  <= 1'b0;
      parity_q     <= '0;
      rem_q        <= '0;
      lat_q        <= '0;
      send_ack_q   <= 1'b0;
      send_rej_q   <= 1'b0;
      tx_active_q  <= 1'b0;
      done_q       <= 1'b0;
      err_status_q <= '0;
    end else begin
      send_ack_q <= 1'b0;
      send_rej_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (send_req) begin
            if ((send_len != 6'd0) && (count_q >= CW'(send_len))) begin
              send_ack_q  <= 1'b1;
              tx_active_q <= 1'b1;
              dut_inp_q   <= {send_len, 2'b00};
              parity_q    <= {send_len, 2'b00};
              inp_valid_q <= 1'b1;
              rem_q       <= send_len;
              state_q     <= HDR;
            end else begin
              send_rej_q <= 1'b1;
            end
          end
        end
        HDR: begin
          if (xfer) begin
            dut_inp_q <= head;
            state_q   <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            parity_q <= parity_q ^ dut_inp_q;
            rem_q    <= rem_q - 1'b1;
            if (rem_q == 6'd1) begin
              dut_inp_q <= parity_q ^ dut_inp_q;
              state_q   <= PARITY;
            end else begin
              dut_inp_q <= head;
            end
          end
        end
        PARITY: begin
          if (xfer) begin
            inp_valid_q <= 1'b0;
            lat_q       <= ERR_LAT_C;
            state_q     <= ERR_WAIT;
          end
        end
        ERR_WAIT: begin
          if (lat_q <= 4'd1) begin
            err_status_q <= error;
            done_q       <= 1'b1;
            tx_active_q  <= 1'b0;
            state_q      <= IDLE;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_full  = full;
  assign fifo_count = count_q;
  assign wr_drop    = wr_drop_q;
  assign send_ack   = send_ack_q;
  assign send_rej   = send_rej_q;
  assign dut_inp    = dut_inp_q;
  assign inp_valid  = inp_valid_q;
  assign tx_active  = tx_active_q;
  assign done       = done_q;
  assign err_status = err_status_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: directed bench for router_pkt_tx with immediate-assertion checks.
module tb_router_pkt_tx;

  logic       clk;
  logic       reset;
  logic       host_wr_en;
  logic [7:0] host_wr_data;
  logic       fifo_full;
  logic [6:0] fifo_count;
  logic       wr_drop;
  logic       send_req;
  logic [5:0] send_len;
  logic       send_ack;
  logic       send_rej;
  logic [7:0] dut_inp;
  logic       inp_valid;
  logic       busy;
  logic [3:0] error;
  logic       tx_active;
  logic       done;
  logic [3:0] err_status;

  int unsigned n_cmp;
  int unsigned n_bad;

  router_pkt_tx #(.FIFO_DEPTH(64), .ERR_LAT(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .host_wr_en   (host_wr_en),
    .host_wr_data (host_wr_data),
    .fifo_full    (fifo_full),
    .fifo_count   (fifo_count),
    .wr_drop      (wr_drop),
    .send_req     (send_req),
    .send_len     (send_len),
    .send_ack     (send_ack),
    .send_rej     (send_rej),
    .dut_inp      (dut_inp),
    .inp_valid    (inp_valid),
    .busy         (busy),
    .error        (error),
    .tx_active    (tx_active),
    .done         (done),
    .err_status   (err_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    host_wr_en   = 1'b1;
    host_wr_data = b;
    tick();
    host_wr_en   = 1'b0;
  endtask

  task automatic req(input logic [5:0] len);
    send_req = 1'b1;
    send_len = len;
    tick();
    send_req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    logic [7:0] exp_b;
    logic [7:0] par;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    host_wr_en = 1'b0;
    host_wr_data = '0;
    send_req = 1'b0;
    send_len = '0;
    busy = 1'b0;
    error = 4'hC;

    tick();
    tick();
    chk("rst_valid", 32'(inp_valid), 32'd0);
    chk("rst_dut_inp", 32'(dut_inp), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_txact", 32'(tx_active), 32'd0);
    chk("rst_err", 32'(err_status), 32'd0);
    reset = 1'b1;
    tick();

    // Test 1: basic 2-byte packet
    wr(8'hA5);
    wr(8'h3C);
    chk("t1_count2", 32'(fifo_count), 32'd2);
    req(6'd2);
    chk("t1_ack", 32'(send_ack), 32'd1);
    chk("t1_txact", 32'(tx_active), 32'd1);
    chk("t1_hdr", 32'({inp_valid, dut_inp}), 32'h108);
    tick();
    chk("t1_ack_pulse", 32'(send_ack), 32'd0);
    chk("t1_b0", 32'({inp_valid, dut_inp}), 32'h1A5);
    chk("t1_count1", 32'(fifo_count), 32'd1);
    tick();
    chk("t1_b1", 32'({inp_valid, dut_inp}), 32'h13C);
    chk("t1_count0", 32'(fifo_count), 32'd0);
    tick();
    chk("t1_par", 32'({inp_valid, dut_inp}), 32'h191);
    tick();
    chk("t1_valid_off", 32'(inp_valid), 32'd0);
    chk("t1_done_e1", 32'(done), 32'd0);
    tick();
    chk("t1_done_e2", 32'(done), 32'd0);
    tick();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_err", 32'(err_status), 32'hC);
    chk("t1_txact_off", 32'(tx_active), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);

    // Test 2: back-pressure on first payload byte
    error = 4'h3;
    wr(8'hA5);
    wr(8'h3C);
    req(6'd2);
    chk("t2_hdr", 32'({inp_valid, dut_inp}), 32'h108);
    tick();
    chk("t2_b0", 32'({inp_valid, dut_inp}), 32'h1A5);
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold", 32'({inp_valid, dut_inp}), 32'h1A5);
    end
    chk("t2_hold_count", 32'(fifo_count), 32'd1);
    busy = 1'b0;
    tick();
    chk("t2_b1", 32'({inp_valid, dut_inp}), 32'h13C);
    tick();
    chk("t2_par", 32'({inp_valid, dut_inp}), 32'h191);
    wait_done("t2_done");
    chk("t2_err", 32'(err_status), 32'h3);

    // Test 3: rejections, then drain the leftover byte
    wr(8'h11);
    chk("t3_count1", 32'(fifo_count), 32'd1);
    req(6'd2);
    chk("t3_rej_len2", 32'({send_rej, send_ack, inp_valid}), 32'b100);
    tick();
    chk("t3_rej_pulse", 32'(send_rej), 32'd0);
    req(6'd0);
    chk("t3_rej_len0", 32'({send_rej, send_ack, inp_valid}), 32'b100);
    req(6'd1);
    chk("t3_ack_len1", 32'({send_ack, inp_valid, dut_inp}), 32'h304);
    tick();
    chk("t3_b0", 32'(dut_inp), 32'h11);
    tick();
    chk("t3_par", 32'(dut_inp), 32'h15);
    wait_done("t3_done");

    // Test 4: fill, overflow, full-with-pop write, 63-byte packet across wrap
    for (int i = 0; i < 64; i++) begin
      wr(8'(i * 7 + 3));
    end
    chk("t4_full", 32'(fifo_full), 32'd1);
    chk("t4_count64", 32'(fifo_count), 32'd64);
    wr(8'hEE);
    chk("t4_drop", 32'(wr_drop), 32'd1);
    chk("t4_drop_count", 32'(fifo_count), 32'd64);
    tick();
    chk("t4_drop_pulse", 32'(wr_drop), 32'd0);
    req(6'd63);
    chk("t4_hdr", 32'({send_ack, inp_valid, dut_inp}), 32'h3FC);
    par = 8'hFC;
    for (int i = 0; i < 63; i++) begin
      if (i == 0) begin
        host_wr_en   = 1'b1;
        host_wr_data = 8'h5A;
      end
      tick();
      host_wr_en = 1'b0;
      if (i == 0) begin
        chk("t4_fullpop_drop", 32'(wr_drop), 32'd0);
        chk("t4_fullpop_count", 32'(fifo_count), 32'd64);
      end
      exp_b = 8'(i * 7 + 3);
      par   = par ^ exp_b;
      chk("t4_payload", 32'({inp_valid, dut_inp}), {23'd0, 1'b1, exp_b});
    end
    tick();
    chk("t4_par", 32'({inp_valid, dut_inp}), {23'd0, 1'b1, par});
    chk("t4_count_left", 32'(fifo_count), 32'd2);
    wait_done("t4_done");

    // Test 5: asynchronous reset mid-payload, then a fresh packet
    wr(8'h33);
    req(6'd3);
    chk("t5_hdr", 32'(dut_inp), 32'h0C);
    tick();
    chk("t5_b0", 32'(dut_inp), 32'hBC);
    tick();
    chk("t5_b1", 32'(dut_inp), 32'h5A);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_async_valid", 32'(inp_valid), 32'd0);
    chk("t5_async_count", 32'(fifo_count), 32'd0);
    chk("t5_async_txact", 32'(tx_active), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("t5_idle_valid", 32'(inp_valid), 32'd0);
    req(6'd1);
    chk("t5_idle_rej", 32'(send_rej), 32'd1);
    wr(8'h7E);
    req(6'd1);
    chk("t5_hdr2", 32'({send_ack, inp_valid, dut_inp}), 32'h304);
    tick();
    chk("t5_pl", 32'({inp_valid, dut_inp}), 32'h17E);
    tick();
    chk("t5_par", 32'({inp_valid, dut_inp}), 32'h17A);
    wait_done("t5_done");

    // Test 6: ignored request mid-packet, error sampled on expiry cycle only
    error = 4'hA;
    wr(8'h01);
    wr(8'h02);
    wr(8'h03);
    req(6'd3);
    chk("t6_hdr", 32'(dut_inp), 32'h0C);
    tick();
    chk("t6_b0", 32'(dut_inp), 32'h01);
    send_req = 1'b1;
    send_len = 6'd1;
    tick();
    chk("t6_b1", 32'(dut_inp), 32'h02);
    chk("t6_noresp1", 32'({send_ack, send_rej}), 32'd0);
    tick();
    chk("t6_b2", 32'(dut_inp), 32'h03);
    chk("t6_noresp2", 32'({send_ack, send_rej}), 32'd0);
    send_req = 1'b0;
    tick();
    chk("t6_par", 32'({inp_valid, dut_inp}), 32'h10C);
    tick();
    chk("t6_valid_off", 32'(inp_valid), 32'd0);
    tick();
    chk("t6_done_e1", 32'(done), 32'd0);
    error = 4'b0101;
    tick();
    error = 4'hA;
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_err", 32'(err_status), 32'h5);
    tick();
    chk("t6_err_hold", 32'({done, tx_active, err_status}), 32'h05);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
